// File: rtl/uart_rx_fsm.sv
// UART receive control FSM with oversampled bit timing.
// Walks start/data/parity/stop bits, strobes the external checkers, reports frame status.
module uart_rx_fsm #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_in,
    input  logic                          par_en,
    input  logic                          strt_glitch,
    input  logic                          par_err,
    input  logic                          stp_err,
    output logic [$clog2(PRESCALE)-1:0]   edge_cnt,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt,
    output logic                          dat_samp_en,
    output logic                          strt_chk_en,
    output logic                          par_chk_en,
    output logic                          stp_chk_en,
    output logic                          deser_en,
    output logic                          data_valid,
    output logic                          frame_err,
    output logic                          parity_fail
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] EDGE_CHK  = EW'(PRESCALE - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          par_en_q, par_en_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_fail_q, parity_fail_d;
    logic          bit_end;

    assign bit_end = (edge_q == EDGE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            edge_q        <= '0;
            bit_q         <= '0;
            par_en_q      <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_q        <= edge_d;
            bit_q         <= bit_d;
            par_en_q      <= par_en_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            parity_fail_q <= parity_fail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        edge_d        = edge_q;
        bit_d         = bit_q;
        par_en_d      = par_en_q;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        parity_fail_d = 1'b0;

        if (state_q != S_IDLE) begin
            edge_d = bit_end ? '0 : edge_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_in) begin
                    state_d  = S_START;
                    par_en_d = par_en;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = strt_glitch ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d       = par_err ? S_IDLE : S_STOP;
                    parity_fail_d = par_err;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d      = S_IDLE;
                    data_valid_d = !stp_err;
                    frame_err_d  = stp_err;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counters always rest at zero whenever the line is idle.
        if (state_d == S_IDLE) begin
            edge_d = '0;
            bit_d  = '0;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = (state_q != S_IDLE);
    assign strt_chk_en = (state_q == S_START)  && (edge_q == EDGE_CHK);
    assign deser_en    = (state_q == S_DATA)   && (edge_q == EDGE_CHK);
    assign par_chk_en  = (state_q == S_PARITY) && (edge_q == EDGE_CHK);
    assign stp_chk_en  = (state_q == S_STOP)   && (edge_q == EDGE_CHK);
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_fail = parity_fail_q;

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter PRESCALE, default 8, oversampling clocks per bit; legal values 8, 16, 32.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_in  input  1  serial line, idle high.
REQ-006 par_en  input  1  1 = frame carries a parity bit.
REQ-007 strt_glitch  input  1  start-check result, valid 1 cycle after strt_chk_en.
REQ-008 par_err  input  1  parity-check result, valid 1 cycle after par_chk_en.
REQ-009 stp_err  input  1  stop-check result, valid 1 cycle after stp_chk_en.
REQ-010 edge_cnt  output  $clog2(PRESCALE)  oversample position within the current bit.
REQ-011 bit_cnt  output  $clog2(DATA_WIDTH)  index of the current data bit.
REQ-012 dat_samp_en  output  1  enables the external sampler.
REQ-013 strt_chk_en, par_chk_en, stp_chk_en, deser_en  output  1 each  single-cycle check/shift strobes.
REQ-014 data_valid, frame_err, parity_fail  output  1 each  registered single-cycle frame status pulses.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, one-hot or binary encoded.
REQ-016 IDLE: rx_in==0 sampled SHALL move to START next cycle with edge_cnt=0; par_en SHALL be latched at this transition and held for the frame.
REQ-017 Outside IDLE, edge_cnt SHALL increment every cycle, wrap PRESCALE-1 -> 0, and the state SHALL be evaluated only at edge_cnt==PRESCALE-1 (bit end).
REQ-018 dat_samp_en SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-019 strt_chk_en (START), deser_en (DATA), par_chk_en (PARITY) and stp_chk_en (STOP) SHALL each be 1 only when edge_cnt==PRESCALE-2 in their state.
REQ-020 START at bit end: strt_glitch==1 -> IDLE, no status pulse; otherwise -> DATA with bit_cnt=0.
REQ-021 DATA at bit end: bit_cnt==DATA_WIDTH-1 -> PARITY if latched par_en else STOP; otherwise bit_cnt+1.
REQ-022 PARITY at bit end: par_err==1 -> IDLE and parity_fail=1 next cycle; otherwise -> STOP.
REQ-023 STOP at bit end: -> IDLE; next cycle data_valid=1 if stp_err==0, else frame_err=1.
REQ-024 data_valid, frame_err and parity_fail SHALL be mutually exclusive and last exactly one cycle.
REQ-025 rx_in==0 in the IDLE cycle that follows a STOP SHALL start a new frame, so back-to-back frames are accepted with no gap cycle.
REQ-026 In IDLE, edge_cnt and bit_cnt SHALL be held at 0.
REQ-027 Strobe outputs SHALL decode from registered state/counters only, with no combinational path from inputs.

Reset
REQ-028 rst==1 at a clock edge SHALL force IDLE, edge_cnt=0, bit_cnt=0, latched par_en=0, and all outputs 0 from that edge.
REQ-029 Reset SHALL take effect mid-frame in any state, with no status pulse issued for the aborted frame.
REQ-030 The first frame after reset release SHALL require a fresh rx_in falling sample in IDLE.

Verification (PRESCALE=8, DATA_WIDTH=8; t0 = IDLE cycle where rx_in==0 is sampled)
REQ-031 Test 0xA5 (LSB first), par_en=0, checkers clean -> 8 deser_en pulses at t0+15+8k (k=0..7), data_valid=1 at t0+81 only.
REQ-032 Test the same frame with par_en=1, par_err=0 -> par_chk_en at t0+79, data_valid at t0+89.
REQ-033 Test strt_glitch=1 at t0+8 -> IDLE at t0+9, dat_samp_en=0 from t0+9, no status pulse, no deser_en.
REQ-034 Test par_en=1 with par_err=1 -> parity_fail pulse at t0+81, stp_chk_en never asserted; separately, test stp_err=1 with par_en=0 -> frame_err at t0+81, data_valid stays 0.
REQ-035 Test rst=1 for one cycle at t0+40 (DATA) -> all outputs 0 at t0+41, no pulse; after release, a new frame completes normally.
REQ-036 Test two back-to-back frames with rx_in low in the IDLE cycle at t0+81 -> second START at t0+82, second data_valid at t0+162.
